// File: rtl/pipelined_rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Holds the default geometry, the add/subtract mode encoding and the
// chunk-size calculation used by the top level.
package pipelined_rca_pkg;

   localparam int DEFAULT_WIDTH  = 16;
   localparam int DEFAULT_STAGES = 4;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Returns bits per stage, or 0 when the width cannot be split evenly
   // into the requested number of stages (caller turns 0 into a fatal).
   function automatic int calcChunk(input int width, input int stages);
      if (stages < 1 || stages > width || (width % stages) != 0) begin
         return 0;
      end
      return width / stages;
   endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder slice built from per-bit
// full-adder equations. Also exposes the carry into the MSB so the
// caller can derive signed overflow from the top slice.
module rca_chunk #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         cmsb
);

   logic [W:0] carry;

   // Ripple the carry bit by bit through textbook full-adder equations.
   always_comb begin
      carry    = '0;
      s        = '0;
      carry[0] = cin;
      for (int i = 0; i < W; i++) begin
         s[i]         = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[W];
   assign cmsb = carry[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/subtract unit with valid/ready handshake.
// The WIDTH-bit operation is split into STAGES chunks; each stage adds one
// chunk and registers the carry for the next. The whole pipe advances as
// one unit whenever the output slot is empty or being consumed.
// Optional build macro PIPELINED_RCA_OVF_EN adds a registered signed
// overflow output 'ovf'.
module pipelined_rca
   import pipelined_rca_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPELINED_RCA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CHUNK_CALC = calcChunk(WIDTH, STAGES);
   localparam int CHUNK      = (CHUNK_CALC > 0) ? CHUNK_CALC : 1;

   if (CHUNK_CALC == 0) begin : g_badConfig
      $fatal(1, "pipelined_rca: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
   end

   logic             advance;
   logic [WIDTH-1:0] bEff;
   logic             cEff;

   logic [WIDTH-1:0] aPipe     [STAGES];
   logic [WIDTH-1:0] bPipe     [STAGES];
   logic [WIDTH-1:0] sumPipe   [STAGES];
   logic             carryPipe [STAGES];
   logic             validPipe [STAGES];

   logic [CHUNK-1:0] chunkSum   [STAGES];
   logic [1:0]       chunkCarry [STAGES];

   assign advance  = !validPipe[STAGES-1] || out_ready;
   assign in_ready = advance;

   assign bEff = (sub == MODE_SUB) ? ~b : b;
   assign cEff = (sub == MODE_SUB) ? 1'b1 : cin;

   // One ripple slice per stage; stage 0 works straight off the ports,
   // later stages work off the operands carried down the pipe.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] opA;
      logic [CHUNK-1:0] opB;
      logic             carryIn;

      if (k == 0) begin : g_first
         assign opA     = a[CHUNK-1:0];
         assign opB     = bEff[CHUNK-1:0];
         assign carryIn = cEff;
      end else begin : g_next
         assign opA     = aPipe[k-1][k*CHUNK +: CHUNK];
         assign opB     = bPipe[k-1][k*CHUNK +: CHUNK];
         assign carryIn = carryPipe[k-1];
      end

      rca_chunk #(
         .W(CHUNK)
      ) u_chunk (
         .a    (opA),
         .b    (opB),
         .cin  (carryIn),
         .s    (chunkSum[k]),
         .cout (chunkCarry[k][1]),
         .cmsb (chunkCarry[k][0])
      );
   end

   // Pipeline registers: the whole pipe shifts together on advance and
   // freezes otherwise, so bubbles keep their slots under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            validPipe[k] <= 1'b0;
            carryPipe[k] <= 1'b0;
            aPipe[k]     <= '0;
            bPipe[k]     <= '0;
            sumPipe[k]   <= '0;
         end
      end else if (advance) begin
         validPipe[0] <= in_valid;
         carryPipe[0] <= chunkCarry[0][1];
         aPipe[0]     <= a;
         bPipe[0]     <= bEff;
         sumPipe[0]   <= WIDTH'(chunkSum[0]);
         for (int k = 1; k < STAGES; k++) begin
            validPipe[k]                  <= validPipe[k-1];
            carryPipe[k]                  <= chunkCarry[k][1];
            aPipe[k]                      <= aPipe[k-1];
            bPipe[k]                      <= bPipe[k-1];
            sumPipe[k]                    <= sumPipe[k-1];
            sumPipe[k][k*CHUNK +: CHUNK]  <= chunkSum[k];
         end
      end
   end

   assign out_valid = validPipe[STAGES-1];
   assign sum       = sumPipe[STAGES-1];
   assign cout      = carryPipe[STAGES-1];

`ifdef PIPELINED_RCA_OVF_EN
   // Signed overflow from the top slice, registered alongside the final sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (advance) begin
         ovf <= chunkCarry[STAGES-1][1] ^ chunkCarry[STAGES-1][0];
      end
   end
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard testbench for pipelined_rca (WIDTH=16, STAGES=4).
// The driver pushes hand-computed expectations as operands are accepted;
// an independent monitor compares whenever a result is presented.
module tb_pipelined_rca;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PIPELINED_RCA_OVF_EN
   logic             ovf;
`endif

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      int               issueCycle;
      bit               checkLat;
      string            name;
   } expT;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic             sub;
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      string            name;
   } vecT;

   expT scoreQ[$];
   int  testsRun   = 0;
   int  failCount  = 0;
   int  cycleCount = 0;
   int  sentCount  = 0;
   int  gotCount   = 0;

   pipelined_rca #(
      .WIDTH (WIDTH),
      .STAGES(STAGES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout)
`ifdef PIPELINED_RCA_OVF_EN
      ,
      .ovf      (ovf)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Offer one operand set; push the expectation on the cycle it is accepted.
   task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic cv, input logic sv,
                                input logic [WIDTH-1:0] expSum, input logic expCout,
                                input logic expOvf, input string name, input bit checkLat);
      int  waitCycles;
      expT e;
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      cin      = cv;
      sub      = sv;
      #1;
      waitCycles = 0;
      while (!in_ready && waitCycles < 50) begin
         @(negedge clk);
         #1;
         waitCycles++;
      end
      checkOutput({name, "_accept"}, in_ready, 1);
      if (in_ready) begin
         e.sum        = expSum;
         e.cout       = expCout;
         e.ovf        = expOvf;
         e.issueCycle = cycleCount;
         e.checkLat   = checkLat;
         e.name       = name;
         scoreQ.push_back(e);
         sentCount++;
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int w;
      w = 0;
      while (scoreQ.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      checkOutput({name, "_drain"}, scoreQ.size(), 0);
   endtask

   // Monitor: compare the presented result with the queue head; pop on transfer.
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid) begin
            if (scoreQ.size() == 0) begin
               testsRun++;
               failCount++;
               $display("[TB] FAIL unexpected_output: got sum 0x%0h cout %0b, expected no result", sum, cout);
            end else begin
               e = scoreQ[0];
               checkOutput({e.name, "_sum"}, sum, e.sum);
               checkOutput({e.name, "_cout"}, cout, e.cout);
`ifdef PIPELINED_RCA_OVF_EN
               checkOutput({e.name, "_ovf"}, ovf, e.ovf);
`endif
               if (out_ready) begin
                  if (e.checkLat) begin
                     checkOutput({e.name, "_latency"}, cycleCount - e.issueCycle, STAGES);
                  end
                  void'(scoreQ.pop_front());
                  gotCount++;
               end
            end
         end
      end
   end

   vecT vecs[9];

   initial begin
      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ripple"};
      vecs[1] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"};
      vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf"};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf"};
      vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, "add_cin"};
      vecs[5] = '{16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_equal"};
      vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, "sub_cin_ignored"};
      vecs[7] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_wrap"};
      vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_neg_ovf"};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      #2;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_sum", sum, 0);
      checkOutput("reset_cout", cout, 0);
      checkOutput("reset_in_ready", in_ready, 1);
`ifdef PIPELINED_RCA_OVF_EN
      checkOutput("reset_ovf", ovf, 0);
`endif

      // Directed single transactions
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                       vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].name, 1'b1);
         idle();
         waitDrain(vecs[i].name);
      end

      // Back-to-back stream, one operand per cycle
      for (int i = 0; i < 20; i++) begin
         logic [WIDTH-1:0] iv;
         iv = WIDTH'(i);
         applyStimulus(iv, WIDTH'(2 * i), iv[0], 1'b0,
                       WIDTH'(3 * i + (i % 2)), 1'b0, 1'b0, "stream", 1'b1);
      end
      idle();
      waitDrain("stream");

      // Backpressure: hold out_ready low for 5 cycles mid-stream
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               applyStimulus(WIDTH'(16'h0100 + k), WIDTH'(16 * k), 1'b0, 1'b0,
                             WIDTH'(16'h0100 + 17 * k), 1'b0, 1'b0, "stall", 1'b0);
            end
            idle();
         end
         begin
            int w;
            w = 0;
            while (!out_valid && w < 50) begin
               @(negedge clk);
               #1;
               w++;
            end
            @(negedge clk);
            out_ready = 1'b0;
            for (int h = 0; h < 5; h++) begin
               #1;
               checkOutput("stall_in_ready", in_ready, 0);
               checkOutput("stall_out_valid", out_valid, 1);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      waitDrain("stall");

      // Reset with three results in flight: none may ever appear
      for (int k = 0; k < 3; k++) begin
         applyStimulus(WIDTH'(16'h0AA0 + k), 16'h0001, 1'b0, 1'b0,
                       WIDTH'(16'h0AA1 + k), 1'b0, 1'b0, "flushed", 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      sentCount -= scoreQ.size();
      scoreQ.delete();
      @(negedge clk);
      rst = 1'b0;
      #2;
      checkOutput("post_reset_sum", sum, 0);
      checkOutput("post_reset_cout", cout, 0);
      for (int c = 0; c < 8; c++) begin
         checkOutput("post_reset_out_valid", out_valid, 0);
         @(negedge clk);
         #2;
      end

      checkOutput("result_count", gotCount, sentCount);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
